// File: rtl/memoryaccess_hs.sv
// MemoryAccess stage with a req/ack data-memory bus: lane steering, load extension, stall and WriteBack latches.
// Optional feature: define MA_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating the offset.
module memoryaccess_hs #(
    parameter int XLEN    = 64,
    parameter int AWIDTH  = 32,
    parameter int PASS_W  = 76,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              phase_ma,
    input  logic              is_load_em,
    input  logic              is_store_em,
    input  logic [2:0]        funct3_em,
    input  logic [XLEN-1:0]   alu_out_em,
    input  logic [XLEN-1:0]   rs2data_em,
    input  logic [PASS_W-1:0] pass_em,
    output logic              dm_req,
    output logic              dm_we,
    output logic [AWIDTH-1:0] dm_addr,
    output logic [XLEN/8-1:0] dm_be,
    output logic [XLEN-1:0]   dm_wdata,
    input  logic [XLEN-1:0]   dm_rdata,
    input  logic              dm_ack,
    output logic              stall_ma,
    output logic [XLEN-1:0]   alu_out_mw,
    output logic [XLEN-1:0]   mem_out_mw,
    output logic [PASS_W-1:0] pass_mw,
    output logic              bus_err_mw,
    output logic              misalign_mw
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;
    state_t r_state, w_next;

    logic              w_memop, w_trap, w_issue, w_direct, w_done, w_timeout, w_tmo_hit;
    logic [2:0]        w_f3;
    logic [1:0]        w_size;
    logic [OFS-1:0]    w_ofs, w_align_m, w_ofs_al;
    logic [XLEN-1:0]   w_rd_shift;
    logic [TW-1:0]     r_tmo;
    logic [OFS-1:0]    r_ofs;
    logic [2:0]        r_f3;
    logic              r_load;
    logic [XLEN-1:0]   r_alu;
    logic [PASS_W-1:0] r_pass;

    // Doubleword forms do not exist on a 32-bit datapath; fold them onto word.
    function automatic logic [2:0] eff_f3(input logic [2:0] f3);
        if (XLEN == 32 && f3[1:0] == 2'b11) return {f3[2], 2'b10};
        return f3;
    endfunction

    function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) m[i] = (i < (1 << sz));
        return m;
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d, input logic [2:0] f3);
        logic [XLEN-1:0] r;
        int              w;
        case (f3[1:0])
            2'b00:   w = 8;
            2'b01:   w = 16;
            2'b10:   w = 32;
            default: w = XLEN;
        endcase
        for (int i = 0; i < XLEN; i++) r[i] = (i < w) ? d[i] : (!f3[2] & d[w-1]);
        return r;
    endfunction

    assign w_memop    = is_load_em | is_store_em;
    assign w_f3       = eff_f3(funct3_em);
    assign w_size     = w_f3[1:0];
    assign w_ofs      = alu_out_em[OFS-1:0];
    assign w_align_m  = OFS'((1 << w_size) - 1);
    assign w_ofs_al   = w_ofs & ~w_align_m;
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
    assign w_rd_shift = dm_rdata >> {r_ofs, 3'b000};
`ifdef MA_MISALIGN_TRAP_EN
    assign w_trap     = w_memop & (|(w_ofs & w_align_m));
`else
    assign w_trap     = 1'b0;
    assign misalign_mw = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (phase_ma && w_memop && !w_trap) w_next = S_BUSY;
            S_BUSY:  if (dm_ack || w_tmo_hit) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall_ma  = 1'b0;
        w_issue   = 1'b0;
        w_direct  = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (phase_ma) begin
                    if (w_memop && !w_trap) begin
                        w_issue  = 1'b1;
                        stall_ma = 1'b1;
                    end else begin
                        w_direct = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (dm_ack)         w_done    = 1'b1;
                else if (w_tmo_hit) w_timeout = 1'b1;
                else                stall_ma  = 1'b1;
            end
            default: ;
        endcase
    end

    // Access context is captured at issue so the bus and result stay coherent while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= '0;
            dm_be      <= '0;
            dm_wdata   <= '0;
            r_tmo      <= '0;
            r_ofs      <= '0;
            r_f3       <= '0;
            r_load     <= 1'b0;
            r_alu      <= '0;
            r_pass     <= '0;
            alu_out_mw <= '0;
            mem_out_mw <= '0;
            pass_mw    <= '0;
            bus_err_mw <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
            misalign_mw <= 1'b0;
`endif
        end else begin
            if (w_issue) begin
                dm_req   <= 1'b1;
                dm_we    <= is_store_em;
                dm_addr  <= {alu_out_em[AWIDTH-1:OFS], {OFS{1'b0}}};
                dm_be    <= size_mask(w_size) << w_ofs_al;
                dm_wdata <= rs2data_em << {w_ofs_al, 3'b000};
                r_tmo    <= '0;
                r_ofs    <= w_ofs_al;
                r_f3     <= w_f3;
                r_load   <= is_load_em;
                r_alu    <= alu_out_em;
                r_pass   <= pass_em;
            end
            if (r_state == S_BUSY && !dm_ack) r_tmo <= r_tmo + 1'b1;
            if (w_done || w_timeout) begin
                dm_req     <= 1'b0;
                dm_we      <= 1'b0;
                alu_out_mw <= r_alu;
                pass_mw    <= r_pass;
                bus_err_mw <= w_timeout;
                mem_out_mw <= (w_done && r_load) ? load_ext(w_rd_shift, r_f3) : '0;
`ifdef MA_MISALIGN_TRAP_EN
                misalign_mw <= 1'b0;
`endif
            end
            if (w_direct) begin
                alu_out_mw <= alu_out_em;
                pass_mw    <= pass_em;
                mem_out_mw <= '0;
                bus_err_mw <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
                misalign_mw <= w_trap;
`endif
            end
        end
    end
endmodule

// File: tb/tb_memoryaccess_hs.sv
// Self-checking bench for memoryaccess_hs (XLEN=64, TIMEOUT=4): vector table plus reset/hold sequences.
module tb_memoryaccess_hs;
    localparam int XLEN = 64, AWIDTH = 32, PASS_W = 76, TIMEOUT = 4;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              phase_ma, is_load_em, is_store_em, dm_req, dm_we, dm_ack, stall_ma;
    logic              bus_err_mw, misalign_mw;
    logic [2:0]        funct3_em;
    logic [XLEN-1:0]   alu_out_em, rs2data_em, dm_wdata, dm_rdata, alu_out_mw, mem_out_mw;
    logic [PASS_W-1:0] pass_em, pass_mw;
    logic [AWIDTH-1:0] dm_addr;
    logic [7:0]        dm_be;

    always #5 clk = ~clk;

    memoryaccess_hs #(.XLEN(XLEN), .AWIDTH(AWIDTH), .PASS_W(PASS_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .phase_ma(phase_ma), .is_load_em(is_load_em),
        .is_store_em(is_store_em), .funct3_em(funct3_em), .alu_out_em(alu_out_em),
        .rs2data_em(rs2data_em), .pass_em(pass_em), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_ack(dm_ack), .stall_ma(stall_ma), .alu_out_mw(alu_out_mw), .mem_out_mw(mem_out_mw),
        .pass_mw(pass_mw), .bus_err_mw(bus_err_mw), .misalign_mw(misalign_mw)
    );

    typedef struct {
        logic ld, st; logic [2:0] f3; logic [63:0] addr, rs2, rdata;
        int ack, busy, stalls;
        logic [7:0] be; logic [31:0] baddr; logic [63:0] wdata, mem; logic err, mis;
    } vec_t;
    typedef struct { logic [63:0] alu, mem; logic [75:0] pass; logic err, mis; } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_cmp = 0, n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] rs2, input logic [63:0] rdata,
                                input int ack, input int busy, input int stalls,
                                input logic [7:0] be, input logic [31:0] baddr, input logic [63:0] wdata,
                                input logic [63:0] mem, input logic err, input logic mis);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
        v.ack = ack; v.busy = busy; v.stalls = stalls; v.be = be; v.baddr = baddr;
        v.wdata = wdata; v.mem = mem; v.err = err; v.mis = mis;
        return v;
    endfunction

    // Drives one op, plays the memory (ack on the v.ack-th BUSY cycle, 0 = never), then scores the latches.
    task automatic run(input vec_t v, input logic [75:0] pass);
        exp_t e;
        int   busy, stalls;
        bit   done;
        @(negedge clk);
        is_load_em = v.ld; is_store_em = v.st; funct3_em = v.f3; alu_out_em = v.addr;
        rs2data_em = v.rs2; pass_em = pass; dm_rdata = v.rdata; dm_ack = 1'b0; phase_ma = 1'b1;
        e.alu = v.addr; e.mem = v.mem; e.pass = pass; e.err = v.err; e.mis = v.mis;
        sb.push_back(e);
        busy = 0; stalls = 0; done = 0;
        for (int c = 0; c < 30; c++) begin
            if (dm_req) begin
                busy++;
                chk("bus_be", dm_be, v.be);
                chk("bus_addr", dm_addr, v.baddr);
                chk("bus_wdata", dm_wdata, v.wdata);
                chk("bus_we", dm_we, v.st);
                dm_ack = (busy == v.ack);
            end else begin
                dm_ack = 1'b0;
            end
            #1;
            if (!stall_ma) begin
                done = 1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_bound: stall_ma still high after 30 cycles, required release");
        end
        @(posedge clk);
        @(negedge clk);
        phase_ma = 1'b0; dm_ack = 1'b0; is_load_em = 1'b0; is_store_em = 1'b0;
        chk("stall_cycles", stalls, v.stalls);
        chk("busy_cycles", busy, v.busy);
        chk("req_dropped", dm_req, 1'b0);
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_empty: got no entry required one");
        end else begin
            e = sb.pop_front();
            chk("alu_out_mw", alu_out_mw, e.alu);
            chk("mem_out_mw", mem_out_mw, e.mem);
            chk("pass_mw", pass_mw, e.pass);
            chk("bus_err_mw", bus_err_mw, e.err);
            chk("misalign_mw", misalign_mw, e.mis);
        end
    endtask

    initial begin
        phase_ma = 0; is_load_em = 0; is_store_em = 0; funct3_em = 0; alu_out_em = 0;
        rs2data_em = 0; pass_em = 0; dm_rdata = 0; dm_ack = 0;
        repeat (2) @(negedge clk);
        chk("rst_dm_req", dm_req, 1'b0);
        chk("rst_dm_be", dm_be, 8'h00);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_stall", stall_ma, 1'b0);
        chk("rst_alu_mw", alu_out_mw, 64'h0);
        chk("rst_mem_mw", mem_out_mw, 64'h0);
        chk("rst_pass_mw", pass_mw, 76'h0);
        chk("rst_err", bus_err_mw, 1'b0);
        chk("rst_mis", misalign_mw, 1'b0);
        rst_n = 1'b1;

        //              ld st f3    addr        rs2                   rdata                 ack busy stl be     baddr      wdata                 mem                   err mis
        tbl.push_back(mk(1, 0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, 1, 1, 8'h08, 32'h1000, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0, 0));
        tbl.push_back(mk(0, 1, 3'b010, 64'h1004, 64'h1122_3344, 64'h0, 3, 3, 3, 8'hF0, 32'h1000, 64'h1122_3344_0000_0000, 64'h0, 0, 0));
        tbl.push_back(mk(1, 0, 3'b101, 64'h1006, 64'h0, 64'hBEEF_0000_0000_0000, 2, 2, 2, 8'hC0, 32'h1000, 64'h0, 64'h0000_0000_0000_BEEF, 0, 0));
        tbl.push_back(mk(1, 0, 3'b011, 64'h2000, 64'h0, 64'h0, 0, 4, 4, 8'hFF, 32'h2000, 64'h0, 64'h0, 1, 0));
`ifdef MA_MISALIGN_TRAP_EN
        tbl.push_back(mk(1, 0, 3'b010, 64'h1002, 64'h0, 64'h0000_0000_8765_4321, 0, 0, 0, 8'h00, 32'h0, 64'h0, 64'h0, 0, 1));
        tbl.push_back(mk(1, 0, 3'b001, 64'h1003, 64'h0, 64'h0000_0000_1234_0000, 0, 0, 0, 8'h00, 32'h0, 64'h0, 64'h0, 0, 1));
`else
        tbl.push_back(mk(1, 0, 3'b010, 64'h1002, 64'h0, 64'h0000_0000_8765_4321, 1, 1, 1, 8'h0F, 32'h1000, 64'h0, 64'hFFFF_FFFF_8765_4321, 0, 0));
        tbl.push_back(mk(1, 0, 3'b001, 64'h1003, 64'h0, 64'h0000_0000_1234_0000, 1, 1, 1, 8'h0C, 32'h1000, 64'h0, 64'h0000_0000_0000_1234, 0, 0));
`endif
        tbl.push_back(mk(0, 0, 3'b000, 64'hDEAD_BEEF_1234_5678, 64'h0, 64'h0, 0, 0, 0, 8'h00, 32'h0, 64'h0, 64'h0, 0, 0));
        tbl.push_back(mk(1, 0, 3'b100, 64'h1007, 64'h0, 64'hA500_0000_0000_0000, 1, 1, 1, 8'h80, 32'h1000, 64'h0, 64'h0000_0000_0000_00A5, 0, 0));
        tbl.push_back(mk(1, 0, 3'b010, 64'h1004, 64'h0, 64'h7FFF_FFFF_0000_0000, 2, 2, 2, 8'hF0, 32'h1000, 64'h0, 64'h0000_0000_7FFF_FFFF, 0, 0));
        tbl.push_back(mk(0, 1, 3'b000, 64'h1005, 64'hAB, 64'h0, 1, 1, 1, 8'h20, 32'h1000, 64'h0000_AB00_0000_0000, 64'h0, 0, 0));
        tbl.push_back(mk(0, 1, 3'b011, 64'h1008, 64'h0102_0304_0506_0708, 64'h0, 2, 2, 2, 8'hFF, 32'h1008, 64'h0102_0304_0506_0708, 64'h0, 0, 0));
        tbl.push_back(mk(1, 0, 3'b001, 64'h100A, 64'h0, 64'h0000_0000_8001_0000, 1, 1, 1, 8'h0C, 32'h1008, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0, 0));
        tbl.push_back(mk(1, 0, 3'b110, 64'h1000, 64'h0, 64'h0000_0000_F000_0001, 3, 3, 3, 8'h0F, 32'h1000, 64'h0, 64'h0000_0000_F000_0001, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            run(tbl[i], {12'(i), 64'hC0DE_0000_0000_0000 | 64'(i)});

        // Latches must hold while phase_ma is low, whatever Execute presents.
        @(negedge clk);
        is_load_em = 1'b1; alu_out_em = 64'h5555_AAAA_5555_AAAA; pass_em = '1;
        repeat (3) @(negedge clk);
        chk("hold_alu", alu_out_mw, 64'h1000);
        chk("hold_mem", mem_out_mw, 64'h0000_0000_F000_0001);
        chk("hold_req", dm_req, 1'b0);
        is_load_em = 1'b0;

        // Reset during BUSY: bus drops at once, latches clear, then a clean LD.
        @(negedge clk);
        is_load_em = 1'b1; funct3_em = 3'b011; alu_out_em = 64'h3000; phase_ma = 1'b1; dm_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_req", dm_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_req", dm_req, 1'b0);
        chk("abort_alu", alu_out_mw, 64'h0);
        chk("abort_mem", mem_out_mw, 64'h0);
        chk("abort_pass", pass_mw, 76'h0);
        chk("abort_be", dm_be, 8'h00);
        @(negedge clk);
        phase_ma = 1'b0; is_load_em = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(mk(1, 0, 3'b011, 64'h3000, 64'h0, 64'h1122_3344_5566_7788, 2, 2, 2, 8'hFF, 32'h3000, 64'h0,
               64'h1122_3344_5566_7788, 0, 0), 76'h7_0000_0000_0000_00AB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
